// File: rtl/led_pkg.sv
// Shared types and defaults for the breathing-LED block: envelope phase
// encoding and the default PWM resolution.
package led_pkg;

  localparam int PWM_BITS_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_HI   = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_LO   = 3'd4
  } phase_t;

endpackage

// File: rtl/led_breather_pwm_core.sv
// Free-running PWM stage: counter, period-aligned duty shadow and a registered
// compare output. clr returns everything to zero on the next edge.
module pwm_core
  import led_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm_out
);

  localparam logic [PWM_BITS-1:0] MAX_D = '1;

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] duty_shadow_q, duty_shadow_d;
  logic                pwm_out_q, pwm_out_d;

  always_comb begin
    pwm_cnt_d     = pwm_cnt_q + 1'b1;
    // Shadow only reloads at the period boundary so a period never mixes two duties.
    duty_shadow_d = (pwm_cnt_q == MAX_D) ? duty : duty_shadow_q;
    pwm_out_d     = (pwm_cnt_q < duty_shadow_q);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pwm_cnt_q     <= '0;
      duty_shadow_q <= '0;
      pwm_out_q     <= 1'b0;
    end else begin
      pwm_cnt_q     <= pwm_cnt_d;
      duty_shadow_q <= duty_shadow_d;
      pwm_out_q     <= pwm_out_d;
    end
  end

  assign pwm_out = pwm_out_q;

endmodule

// File: rtl/led_breather.sv
// Breathing-LED envelope: tick-stepped ramp-up / hold / ramp-down / hold FSM
// with saturating duty arithmetic, feeding a free-running PWM stage.
module led_breather
  import led_pkg::*;
#(
  parameter int PWM_BITS   = PWM_BITS_DEFAULT,
  parameter int STEP       = 1,
  parameter int HOLD_TICKS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                enable,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] duty,
  output logic [2:0]          phase,
  output logic                cycle_done
);

  localparam int HC_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HC_W-1:0]     HOLD_LAST = (HOLD_TICKS > 0) ? HC_W'(HOLD_TICKS - 1) : '0;
  localparam logic [PWM_BITS-1:0] MAX_D     = '1;
  localparam logic [PWM_BITS-1:0] STEP_N    = PWM_BITS'(STEP);
  localparam logic [PWM_BITS:0]   STEP_EXT  = (PWM_BITS + 1)'(STEP);

  phase_t              phase_q, phase_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [HC_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic                cycle_done_q, cycle_done_d;

  logic [PWM_BITS:0]   up_sum;
  logic [PWM_BITS-1:0] up_val;
  logic [PWM_BITS-1:0] down_val;
  logic                pwm_clr;

  // One extra bit on the add lets the clamp see overflow instead of wrapping.
  assign up_sum   = {1'b0, duty_q} + STEP_EXT;
  assign up_val   = (up_sum > {1'b0, MAX_D}) ? MAX_D : up_sum[PWM_BITS-1:0];
  assign down_val = ({1'b0, duty_q} > STEP_EXT) ? (duty_q - STEP_N) : '0;

  always_comb begin
    phase_d      = phase_q;
    duty_d       = duty_q;
    hold_cnt_d   = hold_cnt_q;
    cycle_done_d = 1'b0;
    if (!enable) begin
      phase_d    = IDLE;
      duty_d     = '0;
      hold_cnt_d = '0;
    end else begin
      case (phase_q)
        IDLE: begin
          phase_d = RAMP_UP;
          duty_d  = '0;
        end
        RAMP_UP: begin
          if (tick) begin
            duty_d = up_val;
            if (up_val == MAX_D) begin
              hold_cnt_d = '0;
              if (HOLD_TICKS == 0) phase_d = RAMP_DOWN;
              else                 phase_d = HOLD_HI;
            end
          end
        end
        HOLD_HI: begin
          if (tick) begin
            hold_cnt_d = hold_cnt_q + HC_W'(1);
            if (hold_cnt_q == HOLD_LAST) phase_d = RAMP_DOWN;
          end
        end
        RAMP_DOWN: begin
          if (tick) begin
            duty_d = down_val;
            if (down_val == '0) begin
              hold_cnt_d = '0;
              if (HOLD_TICKS == 0) begin
                phase_d      = RAMP_UP;
                cycle_done_d = 1'b1;
              end else begin
                phase_d = HOLD_LO;
              end
            end
          end
        end
        HOLD_LO: begin
          if (tick) begin
            hold_cnt_d = hold_cnt_q + HC_W'(1);
            if (hold_cnt_q == HOLD_LAST) begin
              phase_d      = RAMP_UP;
              cycle_done_d = 1'b1;
            end
          end
        end
        default: begin
          phase_d    = IDLE;
          duty_d     = '0;
          hold_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= IDLE;
      duty_q       <= '0;
      hold_cnt_q   <= '0;
      cycle_done_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      duty_q       <= duty_d;
      hold_cnt_q   <= hold_cnt_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  assign pwm_clr = rst | ~enable;

  pwm_core #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk    (clk),
    .clr    (pwm_clr),
    .duty   (duty_q),
    .pwm_out(pwm_out)
  );

  assign duty       = duty_q;
  assign phase      = phase_q;
  assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_led_breather.sv
// Three breather instances (STEP/HOLD variants) driven in lockstep and
// compared each cycle against a behavioural envelope/PWM model.
module tb_led_breather;

  logic clk;
  logic rst;
  logic tick;
  logic enable;

  logic [3:0] d_duty [3];
  logic [2:0] d_phase[3];
  logic       d_cd   [3];
  logic       d_pwm  [3];

  int vectors;
  int miscompares;

  led_breather #(.PWM_BITS(4), .STEP(1), .HOLD_TICKS(2)) u0 (
    .clk(clk), .rst(rst), .tick(tick), .enable(enable),
    .pwm_out(d_pwm[0]), .duty(d_duty[0]), .phase(d_phase[0]), .cycle_done(d_cd[0]));
  led_breather #(.PWM_BITS(4), .STEP(6), .HOLD_TICKS(2)) u1 (
    .clk(clk), .rst(rst), .tick(tick), .enable(enable),
    .pwm_out(d_pwm[1]), .duty(d_duty[1]), .phase(d_phase[1]), .cycle_done(d_cd[1]));
  led_breather #(.PWM_BITS(4), .STEP(1), .HOLD_TICKS(0)) u2 (
    .clk(clk), .rst(rst), .tick(tick), .enable(enable),
    .pwm_out(d_pwm[2]), .duty(d_duty[2]), .phase(d_phase[2]), .cycle_done(d_cd[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: phases 0..4 = IDLE, RAMP_UP, HOLD_HI, RAMP_DOWN, HOLD_LO.
  localparam int MAXV = 15;
  int p_step[3] = '{1, 6, 1};
  int p_hold[3] = '{2, 2, 0};
  int m_phase[3], m_duty[3], m_hold[3], m_cd[3];
  int m_cnt[3], m_shadow[3], m_pwm[3];
  int old_duty, nd;

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_phase[k] = 0; m_duty[k] = 0; m_hold[k] = 0; m_cd[k] = 0;
      m_cnt[k] = 0; m_shadow[k] = 0; m_pwm[k] = 0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      old_duty = m_duty[k];
      m_cd[k]  = 0;
      if (rst) begin
        m_phase[k] = 0; m_duty[k] = 0; m_hold[k] = 0;
        m_cnt[k] = 0; m_shadow[k] = 0; m_pwm[k] = 0;
      end else if (!enable) begin
        m_phase[k] = 0; m_duty[k] = 0; m_hold[k] = 0;
        m_cnt[k] = 0; m_shadow[k] = 0; m_pwm[k] = 0;
      end else begin
        m_pwm[k] = (m_cnt[k] < m_shadow[k]) ? 1 : 0;
        if (m_cnt[k] == MAXV) m_shadow[k] = old_duty;
        m_cnt[k] = (m_cnt[k] + 1) % (MAXV + 1);
        case (m_phase[k])
          0: m_phase[k] = 1;
          1: if (tick) begin
               nd = old_duty + p_step[k];
               if (nd >= MAXV) begin
                 nd = MAXV;
                 m_hold[k] = 0;
                 m_phase[k] = (p_hold[k] == 0) ? 3 : 2;
               end
               m_duty[k] = nd;
             end
          2: if (tick) begin
               m_hold[k]++;
               if (m_hold[k] == p_hold[k]) m_phase[k] = 3;
             end
          3: if (tick) begin
               nd = old_duty - p_step[k];
               if (nd <= 0) begin
                 nd = 0;
                 m_hold[k] = 0;
                 if (p_hold[k] == 0) begin m_phase[k] = 1; m_cd[k] = 1; end
                 else m_phase[k] = 4;
               end
               m_duty[k] = nd;
             end
          4: if (tick) begin
               m_hold[k]++;
               if (m_hold[k] == p_hold[k]) begin m_phase[k] = 1; m_cd[k] = 1; end
             end
          default: m_phase[k] = 0;
        endcase
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  int seen_hold_u2;

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      cmp($sformatf("%s u%0d phase", tag, k), int'(d_phase[k]), m_phase[k]);
      cmp($sformatf("%s u%0d duty",  tag, k), int'(d_duty[k]),  m_duty[k]);
      cmp($sformatf("%s u%0d cd",    tag, k), int'(d_cd[k]),    m_cd[k]);
      cmp($sformatf("%s u%0d pwm",   tag, k), int'(d_pwm[k]),   m_pwm[k]);
    end
    if (d_phase[2] == 3'd2 || d_phase[2] == 3'd4) seen_hold_u2++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic r, en, tk;
    int   duty, phase, cd, pwm;
  } vec_t;
  vec_t tbl[9];

  int u1_exp[8] = '{6, 12, 15, 15, 15, 9, 3, 0};
  int cd_pulses, hi_cnt, found;

  initial begin
    vectors = 0; miscompares = 0; seen_hold_u2 = 0;
    rst = 1'b1; tick = 1'b1; enable = 1'b1;

    tbl[0] = '{1'b1, 1'b1, 1'b1, 0, 0, 0, 0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 0, 0, 0, 0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 0, 0, 0, 0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 0, 1, 0, 0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1, 1, 0, 0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1, 1, 0, 0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 2, 1, 0, 0};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 0, 0, 0, 0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 0};

    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].r; enable = tbl[i].en; tick = tbl[i].tk;
      step();
      $display("vec %0d: rst=%0b en=%0b tick=%0b -> duty=%0d phase=%0d cd=%0b pwm=%0b",
               i, tbl[i].r, tbl[i].en, tbl[i].tk, d_duty[0], d_phase[0], d_cd[0], d_pwm[0]);
      cmp($sformatf("tbl%0d duty", i),  int'(d_duty[0]),  tbl[i].duty);
      cmp($sformatf("tbl%0d phase", i), int'(d_phase[0]), tbl[i].phase);
      cmp($sformatf("tbl%0d cd", i),    int'(d_cd[0]),    tbl[i].cd);
      cmp($sformatf("tbl%0d pwm", i),   int'(d_pwm[0]),   tbl[i].pwm);
      check_all("tbl");
    end

    // Full breath: tick every 20 clocks.
    enable = 1'b1; tick = 1'b0;
    step(); check_all("breath");
    cd_pulses = 0;
    for (int t = 1; t <= 36; t++) begin
      for (int c = 0; c < 19; c++) begin
        step(); check_all("breath");
        if (d_cd[0]) cd_pulses++;
      end
      tick = 1'b1;
      step(); check_all("breath");
      tick = 1'b0;
      if (d_cd[0]) cd_pulses++;
      if (t <= 15) cmp($sformatf("ramp u0 tick%0d", t), int'(d_duty[0]), t);
      if (t <= 8)  cmp($sformatf("sat u1 tick%0d", t), int'(d_duty[1]), u1_exp[t-1]);
      if (t == 34) begin
        cmp("breath u0 cd at tick34", int'(d_cd[0]), 1);
        cmp("breath u0 phase at tick34", int'(d_phase[0]), 1);
      end
      if (t == 30) cmp("hold0 u2 cd at tick30", int'(d_cd[2]), 1);
    end
    step(); check_all("breath");
    if (d_cd[0]) cd_pulses++;
    cmp("breath u0 cd pulses", cd_pulses, 1);
    $display("breath: u0 duty=%0d phase=%0d pulses=%0d", d_duty[0], d_phase[0], cd_pulses);

    // PWM shadow: u0 at duty 2 in RAMP_UP; bring it to 8 and let it settle.
    for (int t = 0; t < 6; t++) begin
      tick = 1'b1; step(); check_all("shadow");
      tick = 1'b0; step(); check_all("shadow");
    end
    cmp("shadow u0 duty8", int'(d_duty[0]), 8);
    for (int c = 0; c < 40; c++) begin step(); check_all("shadow"); end
    hi_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      step(); check_all("shadow");
      if (d_pwm[0]) hi_cnt++;
    end
    cmp("shadow duty8 highs", hi_cnt, 8);
    found = 0;
    for (int c = 0; c < 32 && found == 0; c++) begin
      if (m_cnt[0] == 5) found = 1;
      else begin step(); check_all("shadow"); end
    end
    cmp("shadow align found", found, 1);
    tick = 1'b1; step(); check_all("shadow"); tick = 1'b0;
    hi_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      step(); check_all("shadow");
      if (d_pwm[0]) hi_cnt++;
    end
    cmp("shadow old-period highs", hi_cnt, 8);
    hi_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      step(); check_all("shadow");
      if (d_pwm[0]) hi_cnt++;
    end
    cmp("shadow new-period highs", hi_cnt, 9);
    $display("shadow: duty=%0d last period highs=%0d", d_duty[0], hi_cnt);

    // Enable drop at duty 7 in RAMP_UP, coincident with a tick.
    enable = 1'b0; step(); check_all("drop");
    enable = 1'b1; step(); check_all("drop");
    for (int t = 0; t < 7; t++) begin
      tick = 1'b1; step(); check_all("drop");
      tick = 1'b0; step(); check_all("drop");
    end
    cmp("drop u0 duty7", int'(d_duty[0]), 7);
    enable = 1'b0; tick = 1'b1; step(); check_all("drop");
    tick = 1'b0;
    cmp("drop phase idle", int'(d_phase[0]), 0);
    cmp("drop duty 0", int'(d_duty[0]), 0);
    step(); check_all("drop");
    cmp("drop pwm low", int'(d_pwm[0]), 0);
    enable = 1'b1; step(); check_all("drop");
    cmp("reenable phase", int'(d_phase[0]), 1);
    cmp("reenable duty", int'(d_duty[0]), 0);
    tick = 1'b1; step(); check_all("drop"); tick = 1'b0;
    cmp("reenable first step", int'(d_duty[0]), 1);
    $display("drop: re-enabled duty=%0d phase=%0d", d_duty[0], d_phase[0]);

    // Randomized traffic, including rare reset and enable drops.
    for (int c = 0; c < 4000; c++) begin
      rst    = ($urandom_range(0, 499) == 0);
      enable = ($urandom_range(0, 399) != 0);
      tick   = ($urandom_range(0, 3) == 0);
      step(); check_all("rand");
    end
    rst = 1'b0; tick = 1'b0;
    cmp("u2 never in hold phase", seen_hold_u2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
